pipe_run_ctrl: RTL and testbench
================================

Name: pipe_run_ctrl

Overview:
- Run/stop/single-step/breakpoint controller for the 5-stage pipeline.
- Generates the single pipeline advance enable `pipe_en`. `pipe_en` gates the PC, IF_ID, ID_EX, EX_MEM and MEM_WB register updates, replacing the raw stop-gated clock.
- Also keeps cycle and retired-instruction counters for the seven-segment debug display.

Parameters:
- CNT_W, 32, width of cycle_cnt and retire_cnt.
- STEP_W, 8, width of step_count and the internal step_rem counter.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- run_req  in  1  one-cycle pulse: free-run.
- stop_req  in  1  one-cycle pulse: halt.
- step_req  in  1  one-cycle pulse: execute step_count cycles.
- step_count  in  STEP_W  number of cycles per step request; sampled on an accepted step_req.
- bp_enable  in  1  breakpoint compare enable.
- bp_addr  in  32  breakpoint PC.
- pc_if  in  32  current IF-stage PC.
- retire  in  1  MEM_WB holds a valid instruction being written back.
- clr_cnt  in  1  synchronous clear of both counters.
- pipe_en  out  1  pipeline advance enable.
- state  out  2  00 HALT, 01 RUN, 10 STEP, 11 BREAK.
- bp_hit  out  1  one-cycle pulse, registered, on entry to BREAK.
- cycle_cnt  out  CNT_W  count of enabled cycles.
- retire_cnt  out  CNT_W  count of retired instructions.

Behaviour:
- Reset values:
  - state = HALT; pipe_en = 0; bp_hit = 0.
  - step_rem = 0; bp_skip = 0.
  - cycle_cnt = 0; retire_cnt = 0.
  - Reset mid-RUN or mid-STEP aborts immediately and takes the same values.
- Request priority in any state: stop_req > run_req > step_req. Only the highest-priority request present in a cycle is acted on.
- bp_match (combinational) = bp_enable && (pc_if == bp_addr) && !bp_skip.
- pipe_en (combinational) = (state == RUN || state == STEP) && !bp_match.
  - pipe_en is never high in HALT or BREAK.
  - On a match, the PC holds at bp_addr; the instruction at bp_addr is not fetched.
- HALT:
  - run_req -> RUN.
  - step_req with step_count != 0 -> STEP, step_rem <= step_count.
  - step_req with step_count == 0 is ignored (stay HALT).
  - stop_req: stay HALT.
- RUN:
  - stop_req -> HALT.
  - else bp_match -> BREAK, bp_hit = 1 for the next cycle.
  - run_req / step_req: ignored.
- STEP:
  - stop_req -> HALT; step_rem <= 0.
  - else bp_match -> BREAK; step_rem <= 0; bp_hit pulse.
  - else each enabled cycle step_rem decrements; when step_rem == 1 in an enabled cycle -> HALT.
  - Exactly step_count enabled cycles occur.
  - run_req in STEP -> RUN; remaining steps are discarded.
- BREAK:
  - run_req -> RUN with bp_skip <= 1.
  - step_req with step_count != 0 -> STEP with bp_skip <= 1 and step_rem loaded.
  - stop_req -> HALT; bp_skip stays 0.
- bp_skip:
  - Cleared at the end of the first cycle in which pipe_en = 1.
  - Lets execution resume past the breakpoint without re-triggering.
- cycle_cnt: +1 on each cycle with pipe_en = 1; saturates at all-ones.
- retire_cnt: +1 when retire && pipe_en; saturates at all-ones.
- clr_cnt: zeroes both counters; clear wins over a simultaneous increment. State is not affected.
- Changing bp_addr or bp_enable while in BREAK does not change state; the new values are compared from the next cycle.

Test Plan:
1. Reset, then run_req at cycle 2 -> state=01, pipe_en=1 from cycle 3. stop_req at cycle 12 -> state=00, pipe_en=0 from cycle 13, cycle_cnt=10.
2. From HALT, step_req with step_count=3 -> pipe_en high for exactly 3 cycles, then state=00, cycle_cnt=3. step_req with step_count=0 -> no change.
3. bp_enable=1, bp_addr=0x0000_0010, run with pc_if advancing 0,4,8,0xC,0x10 -> pipe_en=0 in the cycle pc_if=0x10, state=11, bp_hit one pulse. run_req -> pc advances to 0x14 with no second break.
4. stop_req, run_req and step_req in the same cycle while in HALT -> stays HALT. run_req+step_req together -> RUN.
5. clr_cnt asserted together with an enabled cycle at cycle_cnt=5 -> cycle_cnt=0. Counters preloaded near all-ones saturate at 0xFFFF_FFFF.
6. reset asserted while in STEP with step_rem=5 -> next cycle state=00, pipe_en=0, counters 0; no further enabled cycles.

Source files
------------

// File: rtl/pipe_run_ctrl.sv
// Run/stop/single-step/breakpoint controller for the 5-stage pipeline.
// Produces the pipeline advance enable and keeps the debug cycle/retire counters.
module pipe_run_ctrl #(
    parameter int CNT_W  = 32,
    parameter int STEP_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run_req,
    input  logic              stop_req,
    input  logic              step_req,
    input  logic [STEP_W-1:0] step_count,
    input  logic              bp_enable,
    input  logic [31:0]       bp_addr,
    input  logic [31:0]       pc_if,
    input  logic              retire,
    input  logic              clr_cnt,
    output logic              pipe_en,
    output logic [1:0]        state,
    output logic              bp_hit,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  retire_cnt
);

    typedef enum logic [1:0] {
        ST_HALT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STEP  = 2'b10,
        ST_BREAK = 2'b11
    } run_state_e;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_STEP,
        REQ_RUN,
        REQ_STOP
    } req_e;

    run_state_e        state_q, state_d;
    logic [STEP_W-1:0] step_rem_q, step_rem_d;
    logic              bp_skip_q, bp_skip_d;
    logic              bp_hit_q, bp_hit_d;
    logic              bp_match;
    logic              step_ok;
    req_e              req;

    // Only the highest-priority request of a cycle is ever acted on.
    always_comb begin
        if (stop_req)      req = REQ_STOP;
        else if (run_req)  req = REQ_RUN;
        else if (step_req) req = REQ_STEP;
        else               req = REQ_NONE;
    end

    assign step_ok  = (req == REQ_STEP) && (step_count != '0);
    assign bp_match = bp_enable && (pc_if == bp_addr) && !bp_skip_q;
    assign pipe_en  = ((state_q == ST_RUN) || (state_q == ST_STEP)) && !bp_match;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
        state_d    = state_q;
        step_rem_d = step_rem_q;
        bp_hit_d   = 1'b0;
        bp_skip_d  = pipe_en ? 1'b0 : bp_skip_q;

        unique case (state_q)
            ST_HALT: begin
                if (req == REQ_RUN) begin
                    state_d = ST_RUN;
                end else if (step_ok) begin
                    state_d    = ST_STEP;
                    step_rem_d = step_count;
                end
            end

            ST_RUN: begin
                if (req == REQ_STOP) begin
                    state_d = ST_HALT;
                end else if (bp_match) begin
                    state_d  = ST_BREAK;
                    bp_hit_d = 1'b1;
                end
            end

            ST_STEP: begin
                if (req == REQ_STOP) begin
                    state_d    = ST_HALT;
                    step_rem_d = '0;
                end else if (bp_match) begin
                    state_d    = ST_BREAK;
                    step_rem_d = '0;
                    bp_hit_d   = 1'b1;
                end else if (req == REQ_RUN) begin
                    state_d    = ST_RUN;
                    step_rem_d = '0;
                end else if (step_rem_q <= STEP_W'(1)) begin
                    state_d    = ST_HALT;
                    step_rem_d = '0;
                end else begin
                    step_rem_d = step_rem_q - STEP_W'(1);
                end
            end

            ST_BREAK: begin
                // Resuming sets bp_skip so the held PC at bp_addr is fetched once.
                if (req == REQ_STOP) begin
                    state_d = ST_HALT;
                end else if (req == REQ_RUN) begin
                    state_d   = ST_RUN;
                    bp_skip_d = 1'b1;
                end else if (step_ok) begin
                    state_d    = ST_STEP;
                    step_rem_d = step_count;
                    bp_skip_d  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (reset) begin
            state_q    <= ST_HALT;
            step_rem_q <= '0;
            bp_skip_q  <= 1'b0;
            bp_hit_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_rem_q <= step_rem_d;
            bp_skip_q  <= bp_skip_d;
            bp_hit_q   <= bp_hit_d;
        end
    end

    // Saturating counters; a clear beats a same-cycle increment.
    always_ff @(posedge clock) begin
        if (reset || clr_cnt) begin
            cycle_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            if (pipe_en && !(&cycle_cnt))
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (pipe_en && retire && !(&retire_cnt))
                retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end

    assign state  = state_q;
    assign bp_hit = bp_hit_q;

    a_no_en_when_stopped: assert property (@(posedge clock) disable iff (reset)
        !(pipe_en && (state_q == ST_HALT || state_q == ST_BREAK)));
    a_hit_only_in_break: assert property (@(posedge clock) disable iff (reset)
        bp_hit_q |-> (state_q == ST_BREAK));
    a_step_rem_live: assert property (@(posedge clock) disable iff (reset)
        (state_q == ST_STEP) |-> (step_rem_q != '0));

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Scoreboard bench for pipe_run_ctrl: stimulus queues per-cycle expectations,
// a monitor samples the DUT after each falling edge and compares.
module tb_pipe_run_ctrl;

    logic        clock;
    logic        reset;
    logic        run_req, stop_req, step_req;
    logic [7:0]  step_count;
    logic        bp_enable;
    logic [31:0] bp_addr, pc_if;
    logic        retire, clr_cnt;

    logic        pipe_en, bp_hit;
    logic [1:0]  state;
    logic [31:0] cycle_cnt, retire_cnt;

    logic        pipe_en_s, bp_hit_s;
    logic [1:0]  state_s;
    logic [3:0]  cycle_cnt_s, retire_cnt_s;

    pipe_run_ctrl #(.CNT_W(32), .STEP_W(8)) dut (
        .clock(clock), .reset(reset), .run_req(run_req), .stop_req(stop_req),
        .step_req(step_req), .step_count(step_count), .bp_enable(bp_enable),
        .bp_addr(bp_addr), .pc_if(pc_if), .retire(retire), .clr_cnt(clr_cnt),
        .pipe_en(pipe_en), .state(state), .bp_hit(bp_hit),
        .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
    );

    // Narrow-counter copy shares all stimulus and is used to observe saturation.
    pipe_run_ctrl #(.CNT_W(4), .STEP_W(8)) dut_s (
        .clock(clock), .reset(reset), .run_req(run_req), .stop_req(stop_req),
        .step_req(step_req), .step_count(step_count), .bp_enable(bp_enable),
        .bp_addr(bp_addr), .pc_if(pc_if), .retire(retire), .clr_cnt(clr_cnt),
        .pipe_en(pipe_en_s), .state(state_s), .bp_hit(bp_hit_s),
        .cycle_cnt(cycle_cnt_s), .retire_cnt(retire_cnt_s)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef enum int {S_STATE, S_PIPE, S_HIT, S_CYC, S_RET, S_CYC4, S_RET4} sel_e;
    typedef struct {
        int          cyc;
        sel_e        sel;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    task automatic tick();
        @(negedge clock);
        cyc++;
        run_req  = 1'b0;
        stop_req = 1'b0;
        step_req = 1'b0;
        clr_cnt  = 1'b0;
    endtask

    task automatic exp_at(input sel_e s, input logic [31:0] v, input string n);
        sb.push_back('{cyc, s, v, n});
    endtask

    initial begin : monitor
        int          mcyc;
        exp_t        e;
        logic [31:0] act;
        mcyc = 0;
        forever begin
            @(negedge clock);
            mcyc++;
            #1;
            while (sb.size() != 0 && sb[0].cyc <= mcyc) begin
                e = sb.pop_front();
                case (e.sel)
                    S_STATE: act = 32'(state);
                    S_PIPE:  act = 32'(pipe_en);
                    S_HIT:   act = 32'(bp_hit);
                    S_CYC:   act = cycle_cnt;
                    S_RET:   act = retire_cnt;
                    S_CYC4:  act = 32'(cycle_cnt_s);
                    default: act = 32'(retire_cnt_s);
                endcase
                checks++;
                if (e.cyc != mcyc) begin
                    errors++;
                    $display("FAIL %s: expectation for cycle %0d checked late at cycle %0d", e.name, e.cyc, mcyc);
                end else if (act !== e.val) begin
                    errors++;
                    $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", e.name, mcyc, act, e.val);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        reset = 1'b1; run_req = 1'b0; stop_req = 1'b0; step_req = 1'b0;
        step_count = 8'd0; bp_enable = 1'b0; bp_addr = 32'h0; pc_if = 32'h0;
        retire = 1'b0; clr_cnt = 1'b0;

        // Reset, then free-run for ten enabled cycles.
        tick();                                     // 1
        tick(); reset = 1'b0;                       // 2
        exp_at(S_STATE, 0, "rst_state"); exp_at(S_PIPE, 0, "rst_pipe");
        exp_at(S_HIT, 0, "rst_hit"); exp_at(S_CYC, 0, "rst_cyc"); exp_at(S_RET, 0, "rst_ret");
        run_req = 1'b1;
        tick();                                     // 3
        exp_at(S_STATE, 1, "run_state"); exp_at(S_PIPE, 1, "run_pipe0"); exp_at(S_CYC, 0, "run_cyc0");
        for (int i = 0; i < 9; i++) begin
            tick();                                 // 4..12
            retire = (cyc >= 5 && cyc <= 8);
            exp_at(S_PIPE, 1, "run_pipe");
        end
        stop_req = 1'b1;
        tick(); retire = 1'b1;                      // 13
        exp_at(S_STATE, 0, "stop_state"); exp_at(S_PIPE, 0, "stop_pipe");
        exp_at(S_CYC, 10, "stop_cyc"); exp_at(S_RET, 4, "stop_ret");
        tick(); retire = 1'b0;                      // 14
        exp_at(S_RET, 4, "halt_no_retire");

        // Single step of three cycles, then a zero-count step request.
        tick();                                     // 15
        clr_cnt = 1'b1; step_count = 8'd3; step_req = 1'b1;
        exp_at(S_STATE, 0, "pre_step_state");
        for (int i = 0; i < 3; i++) begin
            tick();                                 // 16..18
            exp_at(S_STATE, 2, "step_state"); exp_at(S_PIPE, 1, "step_pipe");
        end
        tick();                                     // 19
        exp_at(S_STATE, 0, "step_done_state"); exp_at(S_PIPE, 0, "step_done_pipe"); exp_at(S_CYC, 3, "step_cyc");
        step_count = 8'd0; step_req = 1'b1;
        tick();                                     // 20
        exp_at(S_STATE, 0, "step0_state"); exp_at(S_CYC, 3, "step0_cyc");

        // Request priority.
        tick();                                     // 21
        stop_req = 1'b1; run_req = 1'b1; step_req = 1'b1; step_count = 8'd2;
        tick();                                     // 22
        exp_at(S_STATE, 0, "prio_all_state");
        run_req = 1'b1; step_req = 1'b1;
        tick();                                     // 23
        exp_at(S_STATE, 1, "prio_run_state"); exp_at(S_PIPE, 1, "prio_run_pipe");
        stop_req = 1'b1;
        tick();                                     // 24
        exp_at(S_STATE, 0, "prio_stop_state"); exp_at(S_CYC, 4, "prio_cyc");

        // Breakpoint at 0x10 while running, then resume past it.
        bp_enable = 1'b1; bp_addr = 32'h10; pc_if = 32'h0; run_req = 1'b1;
        tick();                                     // 25
        exp_at(S_STATE, 1, "bp_run_state"); exp_at(S_PIPE, 1, "bp_pipe_pc0");
        for (int i = 1; i <= 3; i++) begin
            tick();                                 // 26..28
            pc_if = 32'(4 * i);
            exp_at(S_PIPE, 1, "bp_pipe_adv");
        end
        tick(); pc_if = 32'h10;                     // 29
        exp_at(S_PIPE, 0, "bp_match_pipe"); exp_at(S_STATE, 1, "bp_match_state"); exp_at(S_HIT, 0, "bp_hit_early");
        tick();                                     // 30
        exp_at(S_STATE, 3, "bp_break_state"); exp_at(S_HIT, 1, "bp_hit_pulse");
        exp_at(S_PIPE, 0, "bp_break_pipe"); exp_at(S_CYC, 8, "bp_cyc");
        tick();                                     // 31
        exp_at(S_STATE, 3, "bp_hold_state"); exp_at(S_HIT, 0, "bp_hit_clear");
        run_req = 1'b1;
        tick();                                     // 32
        exp_at(S_STATE, 1, "bp_resume_state"); exp_at(S_PIPE, 1, "bp_skip_pipe");
        tick(); pc_if = 32'h14;                     // 33
        exp_at(S_PIPE, 1, "bp_past_pipe"); exp_at(S_STATE, 1, "bp_past_state"); exp_at(S_HIT, 0, "bp_no_rehit");
        tick(); pc_if = 32'h18; stop_req = 1'b1;    // 34
        tick();                                     // 35
        exp_at(S_STATE, 0, "bp_stop_state"); exp_at(S_CYC, 11, "bp_stop_cyc");

        // Step into the breakpoint, then step out of BREAK.
        pc_if = 32'h10; step_count = 8'd4; step_req = 1'b1;
        tick();                                     // 36
        exp_at(S_STATE, 2, "bps_state"); exp_at(S_PIPE, 0, "bps_pipe");
        tick();                                     // 37
        exp_at(S_STATE, 3, "bps_break"); exp_at(S_HIT, 1, "bps_hit");
        step_count = 8'd2; step_req = 1'b1;
        tick();                                     // 38
        exp_at(S_STATE, 2, "bps_resume_state"); exp_at(S_PIPE, 1, "bps_skip_pipe");
        tick(); pc_if = 32'h14;                     // 39
        exp_at(S_PIPE, 1, "bps_pipe2");
        tick();                                     // 40
        exp_at(S_STATE, 0, "bps_done_state"); exp_at(S_PIPE, 0, "bps_done_pipe"); exp_at(S_CYC, 13, "bps_cyc");
        bp_enable = 1'b0;

        // Clear against a simultaneous increment, then saturation on the narrow copy.
        clr_cnt = 1'b1; run_req = 1'b1;
        tick();                                     // 41
        exp_at(S_STATE, 1, "clr_run_state"); exp_at(S_CYC, 0, "clr_cyc0"); exp_at(S_RET, 0, "clr_ret0");
        retire = 1'b1;
        repeat (4) tick();                          // 42..45
        tick();                                     // 46
        exp_at(S_CYC, 5, "pre_clr_cyc"); exp_at(S_RET, 5, "pre_clr_ret"); exp_at(S_PIPE, 1, "pre_clr_pipe");
        clr_cnt = 1'b1;
        tick();                                     // 47
        exp_at(S_CYC, 0, "clr_wins_cyc"); exp_at(S_RET, 0, "clr_wins_ret");
        exp_at(S_STATE, 1, "clr_keeps_state"); exp_at(S_CYC4, 0, "clr_cyc4");
        for (int i = 0; i < 20; i++) begin
            tick();                                 // 48..67
            if (cyc == 62) exp_at(S_CYC4, 15, "sat_reach_cyc4");
            if (cyc == 63) begin
                exp_at(S_CYC4, 15, "sat_hold_cyc4"); exp_at(S_CYC, 16, "wide_cyc16");
            end
        end
        exp_at(S_CYC, 20, "wide_cyc20"); exp_at(S_RET, 20, "wide_ret20");
        exp_at(S_CYC4, 15, "sat_cyc4"); exp_at(S_RET4, 15, "sat_ret4");
        retire = 1'b0; stop_req = 1'b1;

        // Reset in the middle of a step sequence.
        tick();                                     // 68
        exp_at(S_STATE, 0, "pre_rst_state");
        step_count = 8'd8; step_req = 1'b1;
        repeat (3) tick();                          // 69..71
        tick();                                     // 72
        exp_at(S_STATE, 2, "mid_step_state"); exp_at(S_PIPE, 1, "mid_step_pipe");
        reset = 1'b1;
        tick(); reset = 1'b0;                       // 73
        exp_at(S_STATE, 0, "rst_step_state"); exp_at(S_PIPE, 0, "rst_step_pipe");
        exp_at(S_HIT, 0, "rst_step_hit"); exp_at(S_CYC, 0, "rst_step_cyc"); exp_at(S_RET, 0, "rst_step_ret");
        for (int i = 0; i < 3; i++) begin
            tick();                                 // 74..76
            exp_at(S_PIPE, 0, "post_rst_pipe"); exp_at(S_CYC, 0, "post_rst_cyc");
        end

        repeat (2) tick();
        if (sb.size() != 0) begin
            errors += sb.size();
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
